// File: rtl/utility_vector_logic_pipe_if.sv
// Handshake/bus bundle for utility_vector_logic_pipe.
//   master : upstream/downstream side. Drives the input beat and out_ready.
//   slave  : pipe side. Drives in_ready and the registered result beat.
// Signals:
//   in_valid, in_ready          input beat handshake
//   in_op[2:0]                  operation select, sampled with the beat
//   vector_a, vector_b          SIZE-bit operands
//   out_valid, out_ready        output beat handshake
//   result_vector               SIZE-bit bitwise result
//   result_zero / result_ones   result is all zeros / all ones
//   result_cnt                  population count of result_vector, full width
interface utility_vector_logic_pipe_if #(
  parameter int unsigned SIZE = 8
);
  localparam int unsigned CNT_W = $clog2(SIZE + 1);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [SIZE-1:0]  vector_a;
  logic [SIZE-1:0]  vector_b;
  logic             out_valid;
  logic             out_ready;
  logic [SIZE-1:0]  result_vector;
  logic             result_zero;
  logic             result_ones;
  logic [CNT_W-1:0] result_cnt;

  modport master (
    output in_valid, in_op, vector_a, vector_b, out_ready,
    input  in_ready, out_valid, result_vector, result_zero, result_ones, result_cnt
  );

  modport slave (
    input  in_valid, in_op, vector_a, vector_b, out_ready,
    output in_ready, out_valid, result_vector, result_zero, result_ones, result_cnt
  );
endinterface

// File: rtl/utility_vector_logic_pipe.sv
// Two-stage pipelined vector logic unit.
// Stage 1 registers the bitwise result of the selected operation on A and B.
// Stage 2 registers that result together with zero/all-ones flags and a
// full-width population count. Valid/ready handshake on both sides with full
// backpressure; up to two beats are held while the output is stalled.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, discards in-flight beats
//   bus  : utility_vector_logic_pipe_if slave modport (see interface file)
module utility_vector_logic_pipe #(
  parameter int unsigned SIZE = 8
) (
  input logic                         clk,
  input logic                         rst,
  utility_vector_logic_pipe_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(SIZE + 1);

  typedef enum logic [2:0] {
    OpAnd    = 3'd0,
    OpOr     = 3'd1,
    OpXor    = 3'd2,
    OpNotA   = 3'd3,
    OpNand   = 3'd4,
    OpNor    = 3'd5,
    OpXnor   = 3'd6,
    OpAndNot = 3'd7
  } op_e;

  logic             s1_valid_q;
  logic [SIZE-1:0]  s1_result_q;
  logic             s2_valid_q;
  logic [SIZE-1:0]  s2_result_q;
  logic             s2_zero_q;
  logic             s2_ones_q;
  logic [CNT_W-1:0] s2_cnt_q;

  logic             s2_advance;
  logic             s1_advance;
  logic [SIZE-1:0]  op_result;
  logic [CNT_W-1:0] s1_cnt;

  // Stage 2 moves whenever its slot is empty or being drained; stage 1 moves
  // whenever its slot is empty or stage 2 takes its beat. in_ready therefore
  // depends on out_ready but never on in_valid.
  assign s2_advance = !s2_valid_q || bus.out_ready;
  assign s1_advance = !s1_valid_q || s2_advance;

  always_comb begin
    op_result = '0;
    unique case (op_e'(bus.in_op))
      OpAnd:    op_result = bus.vector_a & bus.vector_b;
      OpOr:     op_result = bus.vector_a | bus.vector_b;
      OpXor:    op_result = bus.vector_a ^ bus.vector_b;
      OpNotA:   op_result = ~bus.vector_a;
      OpNand:   op_result = ~(bus.vector_a & bus.vector_b);
      OpNor:    op_result = ~(bus.vector_a | bus.vector_b);
      OpXnor:   op_result = ~(bus.vector_a ^ bus.vector_b);
      OpAndNot: op_result = bus.vector_a & ~bus.vector_b;
      default:  op_result = '0;
    endcase
  end

  always_comb begin
    s1_cnt = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      s1_cnt = s1_cnt + CNT_W'(s1_result_q[i]);
    end
  end

  // Data registers only load on an actual transfer so bubbles never carry
  // undefined operands forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_result_q <= '0;
    end else if (s1_advance) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_result_q <= op_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_zero_q   <= 1'b1;
      s2_ones_q   <= 1'b0;
      s2_cnt_q    <= '0;
    end else if (s2_advance) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_result_q <= s1_result_q;
        s2_zero_q   <= (s1_result_q == '0);
        s2_ones_q   <= (s1_result_q == '1);
        s2_cnt_q    <= s1_cnt;
      end
    end
  end

  assign bus.in_ready      = s1_advance;
  assign bus.out_valid     = s2_valid_q;
  assign bus.result_vector = s2_result_q;
  assign bus.result_zero   = s2_zero_q;
  assign bus.result_ones   = s2_ones_q;
  assign bus.result_cnt    = s2_cnt_q;
endmodule
